reg_bus_hub: RTL and testbench

Parametrised register-bus hub between the USB register master and up to NUM_SLAVES register blocks (chipwhisperer, clockglitch, reconfig, …). It replaces ad-hoc OR-combining of slave read data and hyplen with registered, ownership-based muxing. It latches a one-hot owner per transaction, gates slave selection with it, and detects collisions (multiple claimants) and unclaimed addresses. Optional status counters are readable over the same bus.

---
 rtl/reg_bus_hub.sv | 177 +++++++++++++++++
 tb/tb_reg_bus_hub.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_hub.sv
// Register-bus hub: latches a one-hot slave owner per transaction and muxes read data / hyplen.
// Optional hub status register and counters are enabled with REG_HUB_STATUS_EN.
module reg_bus_hub #(
    parameter int unsigned       NUM_SLAVES   = 4,
    parameter int unsigned       ADDR_W       = 6,
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       LEN_W        = 16,
    parameter logic [DATA_W-1:0] DEFAULT_DATA = '0,
    parameter logic [ADDR_W-1:0] STATUS_ADDR  = ADDR_W'(6'h3F)
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic [ADDR_W-1:0]            reg_address_i,
    input  logic [ADDR_W-1:0]            reg_hypaddress_i,
    input  logic [LEN_W-1:0]             reg_bytecnt_i,
    input  logic                         reg_addrvalid_i,
    input  logic                         reg_read_i,
    input  logic                         reg_write_i,
    input  logic [DATA_W-1:0]            reg_datai_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_datao_i,
    input  logic [NUM_SLAVES*LEN_W-1:0]  slv_hyplen_i,
    output logic [NUM_SLAVES-1:0]        slv_sel_o,
    output logic [DATA_W-1:0]            reg_datao_o,
    output logic [LEN_W-1:0]             reg_hyplen_o,
    output logic                         collision_o
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e                state_q;
    logic [NUM_SLAVES-1:0] claim;
    logic [NUM_SLAVES-1:0] first_claim;
    logic [NUM_SLAVES-1:0] owner_q;
    logic                  multi_claim;
    logic [LEN_W-1:0]      first_hyplen;
    logic [DATA_W-1:0]     owner_data;
    logic                  unclaimed_q;
    logic                  status_q;
    logic                  collision_q;
    logic [DATA_W-1:0]     datao_q;
    logic [DATA_W-1:0]     datao_d;
    logic [LEN_W-1:0]      hyplen_q;
    logic [LEN_W-1:0]      hyplen_d;
    logic                  hub_hit;
    logic [DATA_W-1:0]     status_data;
    logic                  unused_inputs;

    // Descending scan so the lowest-index claimant wins.
    always_comb begin
        claim        = '0;
        first_claim  = '0;
        first_hyplen = '0;
        owner_data   = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            claim[i] = |slv_hyplen_i[i*LEN_W +: LEN_W];
            if (claim[i]) begin
                first_claim    = '0;
                first_claim[i] = 1'b1;
                first_hyplen   = slv_hyplen_i[i*LEN_W +: LEN_W];
            end
            if (owner_q[i]) begin
                owner_data = slv_datao_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign multi_claim = |(claim & (claim - NUM_SLAVES'(1)));

`ifdef REG_HUB_STATUS_EN
    logic       status_wr;
    logic [7:0] coll_cnt_q;
    logic [7:0] uncl_cnt_q;

    assign hub_hit   = (reg_hypaddress_i == STATUS_ADDR);
    assign status_wr = reg_addrvalid_i && reg_write_i && (reg_address_i == STATUS_ADDR);

    always_comb begin
        status_data = '0;
        if (reg_bytecnt_i == LEN_W'(0)) begin
            status_data = DATA_W'(coll_cnt_q);
        end else if (reg_bytecnt_i == LEN_W'(1)) begin
            status_data = DATA_W'(uncl_cnt_q);
        end else if (reg_bytecnt_i == LEN_W'(2)) begin
            status_data = DATA_W'(collision_q);
        end
    end
`else
    assign hub_hit     = 1'b0;
    assign status_data = '0;
`endif

    assign unused_inputs = ^{reg_datai_i, reg_read_i, reg_address_i, reg_bytecnt_i, STATUS_ADDR};

    assign hyplen_d = hub_hit ? LEN_W'(3) : first_hyplen;

    // Gating with addrvalid keeps the previous owner's data off the bus after a fall.
    always_comb begin
        datao_d = '0;
        if (state_q == StActive && reg_addrvalid_i) begin
            if (status_q) begin
                datao_d = status_data;
            end else if (unclaimed_q) begin
                datao_d = DEFAULT_DATA;
            end else begin
                datao_d = owner_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            unclaimed_q <= 1'b0;
            status_q    <= 1'b0;
            collision_q <= 1'b0;
            datao_q     <= '0;
            hyplen_q    <= '0;
`ifdef REG_HUB_STATUS_EN
            coll_cnt_q  <= '0;
            uncl_cnt_q  <= '0;
`endif
        end else begin
            hyplen_q <= hyplen_d;
            datao_q  <= datao_d;
            unique case (state_q)
                StIdle: begin
                    if (reg_addrvalid_i) begin
                        state_q <= StActive;
                        if (hub_hit) begin
                            owner_q     <= '0;
                            unclaimed_q <= 1'b0;
                            status_q    <= 1'b1;
                        end else begin
                            owner_q     <= first_claim;
                            unclaimed_q <= (claim == '0);
                            status_q    <= 1'b0;
                            if (multi_claim) begin
                                collision_q <= 1'b1;
                            end
`ifdef REG_HUB_STATUS_EN
                            if (multi_claim && coll_cnt_q != 8'hFF) begin
                                coll_cnt_q <= coll_cnt_q + 8'd1;
                            end
                            if (claim == '0 && uncl_cnt_q != 8'hFF) begin
                                uncl_cnt_q <= uncl_cnt_q + 8'd1;
                            end
`endif
                        end
                    end
                end
                StActive: begin
                    if (!reg_addrvalid_i) begin
                        state_q     <= StIdle;
                        owner_q     <= '0;
                        unclaimed_q <= 1'b0;
                        status_q    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
`ifdef REG_HUB_STATUS_EN
            if (status_wr) begin
                coll_cnt_q  <= '0;
                uncl_cnt_q  <= '0;
                collision_q <= 1'b0;
            end
`endif
        end
    end

    assign slv_sel_o    = owner_q;
    assign reg_datao_o  = datao_q;
    assign reg_hyplen_o = hyplen_q;
    assign collision_o  = collision_q;

endmodule

// File: tb/tb_reg_bus_hub.sv
// Directed, table-driven bench for reg_bus_hub (4 slaves, DEFAULT_DATA = 0xEE).
module tb_reg_bus_hub;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [5:0]  reg_address_i;
    logic [5:0]  reg_hypaddress_i;
    logic [15:0] reg_bytecnt_i;
    logic        reg_addrvalid_i;
    logic        reg_read_i;
    logic        reg_write_i;
    logic [7:0]  reg_datai_i;
    logic [31:0] slv_datao_i;
    logic [63:0] slv_hyplen_i;
    logic [3:0]  slv_sel_o;
    logic [7:0]  reg_datao_o;
    logic [15:0] reg_hyplen_o;
    logic        collision_o;

    int checks = 0;
    int errors = 0;

    reg_bus_hub #(
        .NUM_SLAVES  (4),
        .ADDR_W      (6),
        .DATA_W      (8),
        .LEN_W       (16),
        .DEFAULT_DATA(8'hEE),
        .STATUS_ADDR (6'h3F)
    ) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .reg_address_i   (reg_address_i),
        .reg_hypaddress_i(reg_hypaddress_i),
        .reg_bytecnt_i   (reg_bytecnt_i),
        .reg_addrvalid_i (reg_addrvalid_i),
        .reg_read_i      (reg_read_i),
        .reg_write_i     (reg_write_i),
        .reg_datai_i     (reg_datai_i),
        .slv_datao_i     (slv_datao_i),
        .slv_hyplen_i    (slv_hyplen_i),
        .slv_sel_o       (slv_sel_o),
        .reg_datao_o     (reg_datao_o),
        .reg_hyplen_o    (reg_hyplen_o),
        .collision_o     (collision_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [63:0] hyp;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [7:0]  dout;
        logic [15:0] hlen;
        logic        coll;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outs(input string name);
        check({name, "_sel"}, 32'(slv_sel_o), 32'h0);
        check({name, "_dout"}, 32'(reg_datao_o), 32'h0);
    endtask

    task automatic start_txn(input logic [5:0] addr, input logic [63:0] hyp, input logic [31:0] dat);
        reg_address_i    = addr;
        reg_hypaddress_i = addr;
        slv_hyplen_i     = hyp;
        slv_datao_i      = dat;
        reg_addrvalid_i  = 1'b1;
    endtask

`ifdef REG_HUB_STATUS_EN
    // Reads status bytes 0..3 in one transaction; datao follows bytecnt with 1-cycle latency.
    task automatic status_read(input string name, input logic [63:0] hyp, input logic [7:0] e0,
                               input logic [7:0] e1, input logic [7:0] e2);
        reg_bytecnt_i = 16'd0;
        reg_read_i    = 1'b1;
        start_txn(6'h3F, hyp, 32'h66666666);
        tick();
        check({name, "_sel"}, 32'(slv_sel_o), 32'h0);
        check({name, "_hyplen"}, 32'(reg_hyplen_o), 32'h3);
        tick();
        check({name, "_b0"}, 32'(reg_datao_o), 32'(e0));
        reg_bytecnt_i = 16'd1;
        tick();
        check({name, "_b1"}, 32'(reg_datao_o), 32'(e1));
        reg_bytecnt_i = 16'd2;
        tick();
        check({name, "_b2"}, 32'(reg_datao_o), 32'(e2));
        reg_bytecnt_i = 16'd3;
        tick();
        check({name, "_b3"}, 32'(reg_datao_o), 32'h0);
        reg_addrvalid_i = 1'b0;
        reg_read_i      = 1'b0;
        reg_bytecnt_i   = 16'd0;
        slv_hyplen_i    = '0;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{6'h05, 64'h0000_0000_0004_0000, 32'h33_22_A5_11, 4'b0010, 8'hA5, 16'h0004, 1'b0};
        vecs[1] = '{6'h20, 64'h0,                   32'h44_33_22_11, 4'b0000, 8'hEE, 16'h0000, 1'b0};
        vecs[2] = '{6'h07, 64'h0100_0000_0000_0000, 32'h3C_12_34_56, 4'b1000, 8'h3C, 16'h0100, 1'b0};
        vecs[3] = '{6'h08, 64'h0000_0000_0000_0001, 32'h81_82_83_5A, 4'b0001, 8'h5A, 16'h0001, 1'b0};
        vecs[4] = '{6'h10, 64'h0000_0009_0000_0002, 32'h00_99_88_77, 4'b0001, 8'h77, 16'h0002, 1'b1};
        vecs[5] = '{6'h11, 64'h0000_0006_0000_0000, 32'h01_C3_02_03, 4'b0100, 8'hC3, 16'h0006, 1'b1};

        reset_i          = 1'b1;
        reg_address_i    = '0;
        reg_hypaddress_i = '0;
        reg_bytecnt_i    = '0;
        reg_addrvalid_i  = 1'b0;
        reg_read_i       = 1'b0;
        reg_write_i      = 1'b0;
        reg_datai_i      = '0;
        slv_datao_i      = 32'hFFFF_FFFF;
        slv_hyplen_i     = 64'h0000_0000_0000_0005;
        tick();
        tick();
        check_idle_outs("reset");
        check("reset_hyplen", 32'(reg_hyplen_o), 32'h0);
        check("reset_coll", 32'(collision_o), 32'h0);
        slv_hyplen_i = '0;
        slv_datao_i  = '0;
        reset_i      = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            reg_read_i = 1'b1;
            start_txn(vecs[v].addr, vecs[v].hyp, vecs[v].dat);
            tick();
            check($sformatf("v%0d_sel", v), 32'(slv_sel_o), 32'(vecs[v].sel));
            check($sformatf("v%0d_hyplen", v), 32'(reg_hyplen_o), 32'(vecs[v].hlen));
            check($sformatf("v%0d_coll", v), 32'(collision_o), 32'(vecs[v].coll));
            check($sformatf("v%0d_dout_early", v), 32'(reg_datao_o), 32'h0);
            tick();
            check($sformatf("v%0d_dout", v), 32'(reg_datao_o), 32'(vecs[v].dout));
            reg_addrvalid_i = 1'b0;
            reg_read_i      = 1'b0;
            tick();
            check_idle_outs($sformatf("v%0d_fall", v));
            check($sformatf("v%0d_coll_sticky", v), 32'(collision_o), 32'(vecs[v].coll));
            slv_hyplen_i = '0;
            tick();
            check($sformatf("v%0d_hyplen_clr", v), 32'(reg_hyplen_o), 32'h0);
        end

        // Write to an unclaimed address selects nobody.
        reg_write_i = 1'b1;
        reg_datai_i = 8'h5C;
        start_txn(6'h20, 64'h0, 32'h11111111);
        tick();
        check("uncl_wr_sel", 32'(slv_sel_o), 32'h0);
        reg_write_i     = 1'b0;
        reg_addrvalid_i = 1'b0;
        tick();

        // Reset while slave 2 owns the bus, then re-latch with addrvalid held.
        start_txn(6'h12, 64'h0000_0005_0000_0000, 32'h00_44_00_00);
        tick();
        check("rst_pre_sel", 32'(slv_sel_o), 32'h4);
        tick();
        check("rst_pre_dout", 32'(reg_datao_o), 32'h44);
        #2;
        reset_i = 1'b1;
        #1;
        check_idle_outs("rst_async");
        check("rst_async_hyplen", 32'(reg_hyplen_o), 32'h0);
        check("rst_async_coll", 32'(collision_o), 32'h0);
        tick();
        #2;
        reset_i = 1'b0;
        tick();
        check("rst_relatch_sel", 32'(slv_sel_o), 32'h4);
        tick();
        check("rst_relatch_dout", 32'(reg_datao_o), 32'h44);
        reg_addrvalid_i = 1'b0;
        slv_hyplen_i    = '0;
        tick();
        tick();

        // Back-to-back: owner 3, one idle cycle, owner 0.
        start_txn(6'h07, 64'h0001_0000_0000_0000, 32'h3C_00_00_5A);
        tick();
        check("b2b_sel3", 32'(slv_sel_o), 32'h8);
        tick();
        check("b2b_dout3", 32'(reg_datao_o), 32'h3C);
        reg_addrvalid_i = 1'b0;
        tick();
        check_idle_outs("b2b_gap");
        start_txn(6'h08, 64'h0000_0000_0000_0001, 32'h3C_00_00_5A);
        tick();
        check("b2b_sel0", 32'(slv_sel_o), 32'h1);
        check("b2b_dout_nostale", 32'(reg_datao_o), 32'h0);
        tick();
        check("b2b_dout0", 32'(reg_datao_o), 32'h5A);
        reg_addrvalid_i = 1'b0;
        slv_hyplen_i    = '0;
        tick();
        check("b2b_coll", 32'(collision_o), 32'h0);

        // 300 collisions between slaves 0 and 1.
        for (int n = 0; n < 300; n++) begin
            start_txn(6'h10, 64'h0000_0000_0002_0003, 32'h0);
            tick();
            reg_addrvalid_i = 1'b0;
            tick();
        end
        check("coll300_flag", 32'(collision_o), 32'h1);
        start_txn(6'h21, 64'h0, 32'h0);
        tick();
        reg_addrvalid_i = 1'b0;
        tick();

`ifdef REG_HUB_STATUS_EN
        status_read("stat1", 64'h0, 8'hFF, 8'h01, 8'h01);
        reg_write_i = 1'b1;
        start_txn(6'h3F, 64'h0, 32'h0);
        tick();
        reg_write_i     = 1'b0;
        reg_addrvalid_i = 1'b0;
        tick();
        check("stat_clr_coll", 32'(collision_o), 32'h0);
        status_read("stat2", 64'h0000_0000_0000_0007, 8'h00, 8'h00, 8'h00);
`else
        // Without the status block, STATUS_ADDR is an ordinary slave address.
        reg_read_i = 1'b1;
        start_txn(6'h3F, 64'h0000_0000_0000_0007, 32'h00_00_00_66);
        tick();
        check("addr3f_sel", 32'(slv_sel_o), 32'h1);
        check("addr3f_hyplen", 32'(reg_hyplen_o), 32'h7);
        tick();
        check("addr3f_dout", 32'(reg_datao_o), 32'h66);
        reg_addrvalid_i = 1'b0;
        reg_read_i      = 1'b0;
        slv_hyplen_i    = '0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
